sync_to_ldl_bridge: RTL

//  Clocked producer-side front end for the asynchronous LDL pipeline.

---
 rtl/sync_to_ldl_bridge_pkg.sv | 13 +
 rtl/ldl_ack_sync.sv | 24 ++
 rtl/sync_to_ldl_bridge.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/sync_to_ldl_bridge_pkg.sv
// Shared definitions for the sync-to-LDL bridge: handshake FSM states and defaults.
package sync_to_ldl_bridge_pkg;

   localparam int unsigned LDL_DEFAULT_DATA_WIDTH = 8;

   typedef enum logic [1:0] {
      LDL_ST_IDLE  = 2'd0,
      LDL_ST_SETUP = 2'd1,
      LDL_ST_REQ   = 2'd2,
      LDL_ST_RTZ   = 2'd3
   } ldl_state_e;

endpackage

// File: rtl/ldl_ack_sync.sv
// Multi-flop synchronizer for the asynchronous 4-phase acknowledge; resets to 1.
module ldl_ack_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic ack_i,
   output logic ack_s_o
);

   logic [SYNC_STAGES-1:0] sync_q;

   // Resetting to 1 makes the IDLE ack-low guard hold off until a real low is seen.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], ack_i};
      end
   end

   assign ack_s_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/sync_to_ldl_bridge.sv
// Valid/ready source -> FIFO -> 4-phase bundled-data request to the first LDL stage.
// Optional macro LDL_SETUP_EXT_EN adds SETUP_CYCLES of data-to-req setup time.
module sync_to_ldl_bridge
   import sync_to_ldl_bridge_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = LDL_DEFAULT_DATA_WIDTH,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned SETUP_CYCLES = 2
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [DATA_WIDTH-1:0]       in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic [DATA_WIDTH-1:0]       out_data,
   output logic                        out_req,
   input  logic                        out_ack,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        busy
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;
`ifdef LDL_SETUP_EXT_EN
   localparam bit EXT_EN = 1'b1;
`else
   localparam bit EXT_EN = 1'b0;
`endif
   localparam int unsigned SETUP_LEN = EXT_EN ? 1 + SETUP_CYCLES : 1;

   logic                  ack_s;
   logic                  push;
   logic                  pop;
   logic                  empty;
   logic                  setup_done;

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]      level_q, level_d;

   ldl_state_e            state_q, state_d;
   logic                  out_req_q, out_req_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

   ldl_ack_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_ack_sync (
      .clk    (clk),
      .reset_n(reset_n),
      .ack_i  (out_ack),
      .ack_s_o(ack_s)
   );

   assign in_ready   = (level_q != LVL_W'(FIFO_DEPTH));
   assign empty      = (level_q == '0);
   assign push       = in_valid & in_ready;
   assign fifo_level = level_q;
   assign out_data   = out_data_q;
   assign out_req    = out_req_q;
   assign busy       = (state_q != LDL_ST_IDLE);

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

`ifdef LDL_SETUP_EXT_EN
   localparam int unsigned CNT_W = $clog2(SETUP_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign setup_done = (cnt_q == CNT_W'(SETUP_LEN - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (pop) begin
         cnt_d = '0;
      end else if ((state_q == LDL_ST_SETUP) && !setup_done) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   // Single-cycle setup: SETUP always exits on its first cycle.
   assign setup_done = (SETUP_LEN == 1);
`endif

   // out_data is only reloaded on a pop, which never happens in REQ or RTZ before ack_s falls.
   always_comb begin
      state_d    = state_q;
      out_req_d  = out_req_q;
      out_data_d = out_data_q;
      pop        = 1'b0;
      unique case (state_q)
         LDL_ST_IDLE: begin
            if (!empty && !ack_s) begin
               pop        = 1'b1;
               out_data_d = mem_q[rd_ptr_q];
               state_d    = LDL_ST_SETUP;
            end
         end
         LDL_ST_SETUP: begin
            out_req_d = 1'b0;
            if (setup_done) begin
               out_req_d = 1'b1;
               state_d   = LDL_ST_REQ;
            end
         end
         LDL_ST_REQ: begin
            if (ack_s) begin
               out_req_d = 1'b0;
               state_d   = LDL_ST_RTZ;
            end
         end
         LDL_ST_RTZ: begin
            out_req_d = 1'b0;
            if (!ack_s) begin
               if (!empty) begin
                  pop        = 1'b1;
                  out_data_d = mem_q[rd_ptr_q];
                  state_d    = LDL_ST_SETUP;
               end else begin
                  state_d = LDL_ST_IDLE;
               end
            end
         end
         default: begin
            out_req_d = 1'b0;
            state_d   = LDL_ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= LDL_ST_IDLE;
         out_req_q  <= 1'b0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         out_req_q  <= out_req_d;
         out_data_q <= out_data_d;
      end
   end

endmodule
